// File: rtl/banner_scroller.sv
// Banner scroller: windows a wide red/green message bitmap onto the LED matrix
// with static, scroll-left, scroll-right and blink animation, stepped by an
// internal clock divider.
module banner_scroller #(
    parameter int ROWS        = 16,
    parameter int COLS        = 16,
    parameter int MSG_COLS    = 32,
    parameter int STEP_CYCLES = 25000000,
    localparam int OFF_W      = (MSG_COLS > 1) ? $clog2(MSG_COLS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     restart,
    input  logic [1:0]               mode,
    input  logic [ROWS*MSG_COLS-1:0] msg_red,
    input  logic [ROWS*MSG_COLS-1:0] msg_grn,
    output logic [ROWS*COLS-1:0]     RedPixels,
    output logic [ROWS*COLS-1:0]     GrnPixels,
    output logic [OFF_W-1:0]         offset,
    output logic                     step,
    output logic                     wrap
);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
    localparam logic [1:0] MODE_RIGHT  = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam int               DIV_W    = $clog2(STEP_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);
    localparam logic [OFF_W-1:0] OFF_MAX  = OFF_W'(MSG_COLS - 1);
    localparam logic [OFF_W:0]   MSG_X    = (OFF_W + 1)'(MSG_COLS);

    logic [DIV_W-1:0]     div_q, div_d;
    logic [OFF_W-1:0]     off_q, off_d;
    logic                 vis_q, vis_d;
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;
    logic                 step_ev;
    logic                 vis_eff;
    logic [ROWS*COLS-1:0] red_q, red_d;
    logic [ROWS*COLS-1:0] grn_q, grn_d;
    logic [OFF_W-1:0]     col_idx [COLS];

    // Divider, offset, visibility and pulse next-state; restart overrides a coincident step.
    always_comb begin
        step_ev = enable && (div_q == DIV_LAST);
        div_d   = div_q;
        off_d   = off_q;
        vis_d   = vis_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (restart) begin
            div_d = '0;
            off_d = '0;
            vis_d = 1'b1;
        end else if (enable) begin
            div_d = step_ev ? '0 : div_q + 1'b1;
            if (mode != MODE_BLINK) begin
                vis_d = 1'b1;
            end
            if (step_ev) begin
                step_d = 1'b1;
                case (mode)
                    MODE_LEFT: begin
                        if (off_q == '0) begin
                            off_d  = OFF_MAX;
                            wrap_d = 1'b1;
                        end else begin
                            off_d = off_q - 1'b1;
                        end
                    end
                    MODE_RIGHT: begin
                        if (off_q == OFF_MAX) begin
                            off_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            off_d = off_q + 1'b1;
                        end
                    end
                    MODE_BLINK:  vis_d = ~vis_q;
                    MODE_STATIC: ;
                    default:     ;
                endcase
            end
        end
    end

    // Non-blink modes show the message immediately, even if the blink phase was blank.
    assign vis_eff = vis_q | (mode != MODE_BLINK);

    // Message column shown in display column c: (offset + c) wrapped by explicit compare.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam logic [OFF_W:0] C_X = (OFF_W + 1)'(c);
        logic [OFF_W:0] sum;
        assign sum        = {1'b0, off_q} + C_X;
        assign col_idx[c] = (sum >= MSG_X) ? OFF_W'(sum - MSG_X) : sum[OFF_W-1:0];
    end

    // Per-row gather of the visible window for red and green.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [MSG_COLS-1:0] row_red;
        logic [MSG_COLS-1:0] row_grn;
        assign row_red = msg_red[r*MSG_COLS +: MSG_COLS];
        assign row_grn = msg_grn[r*MSG_COLS +: MSG_COLS];
        for (genvar c = 0; c < COLS; c++) begin : g_pix
            assign red_d[r*COLS+c] = vis_eff & row_red[col_idx[c]];
            assign grn_d[r*COLS+c] = vis_eff & row_grn[col_idx[c]];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            off_q  <= '0;
            vis_q  <= 1'b1;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            off_q  <= off_d;
            vis_q  <= vis_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    // Pixel registers reload every enabled cycle and hold while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red_q <= '0;
            grn_q <= '0;
        end else if (enable) begin
            red_q <= red_d;
            grn_q <= grn_d;
        end
    end

    assign RedPixels = red_q;
    assign GrnPixels = grn_q;
    assign offset    = off_q;
    assign step      = step_q;
    assign wrap      = wrap_q;

endmodule
